// File: rtl/iic_seq.sv
// iic_seq: register-transaction sequencer driving iic_core byte strobes
module iic_seq #(
  parameter int TIMEOUT = 4096
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  input  logic       op,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       core_start,
  output logic       core_stop,
  output logic       core_rw,
  output logic [7:0] core_din,
  input  logic [7:0] core_dout,
  input  logic       core_busy
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACC, S_WAIT_DONE, S_ABORT, S_DONE} state_t;
  state_t state, state_n;
  logic [2:0] step;
  logic [CW-1:0] cnt;
  logic op_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wd_q;
  logic stop_step, last, tmo, active;
  logic [7:0] step_din;
  assign stop_step = op_q ? (step == 3'd2 || step == 3'd5) : step == 3'd3;
  assign last = step == (op_q ? 3'd5 : 3'd3);
  // the counter ends one short so the abort follows TIMEOUT-1 cycles in a phase
  assign tmo = cnt == CW'(TIMEOUT - 2);
  assign active = state == S_ISSUE || state == S_WAIT_ACC || state == S_WAIT_DONE;
  assign step_din = step == 3'd0 ? {dev_q, 1'b0} :
                    step == 3'd1 ? reg_q :
                    !op_q        ? wd_q :
                    step == 3'd3 ? {dev_q, 1'b1} : 8'h00;
  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_n;
  // next-state: each handshake phase falls through to ABORT on timeout
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      state_n = req ? S_ISSUE : S_IDLE;
      S_ISSUE:     state_n = !core_busy ? S_WAIT_ACC : tmo ? S_ABORT : S_ISSUE;
      S_WAIT_ACC:  state_n = core_busy ? S_WAIT_DONE : tmo ? S_ABORT : S_WAIT_ACC;
      S_WAIT_DONE: state_n = !core_busy ? (last ? S_DONE : S_ISSUE) : tmo ? S_ABORT : S_WAIT_DONE;
      S_ABORT:     state_n = S_DONE;
      S_DONE:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end
  // outputs: strobes fire only once the core is idle; din/rw held across the whole step
  always_comb begin
    busy       = state != S_IDLE;
    done       = state == S_DONE;
    core_start = state == S_ISSUE && !core_busy && !stop_step;
    core_stop  = (state == S_ISSUE && !core_busy && stop_step) || state == S_ABORT;
    core_din   = active ? step_din : 8'h00;
    core_rw    = active && op_q && step == 3'd4;
  end
  // request latch, step/timeout tracking, read capture and error flag
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      step  <= '0;
      cnt   <= '0;
      op_q  <= 1'b0;
      dev_q <= '0;
      reg_q <= '0;
      wd_q  <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      if (state == S_IDLE && req) begin
        op_q  <= op;
        dev_q <= dev_addr;
        reg_q <= reg_addr;
        wd_q  <= wdata;
        err   <= 1'b0;
        step  <= '0;
      end
      if (state == S_ABORT) err <= 1'b1;
      if (state == S_WAIT_DONE && !core_busy) begin
        step <= step + 3'd1;
        if (op_q && step == 3'd4) rdata <= core_dout;
      end
      cnt <= (state_n != state || !active) ? '0 : cnt + 1'b1;
    end
endmodule

// File: tb/tb_iic_seq.sv
// tb_iic_seq: directed checks of iic_seq against a behavioural core model
module tb_iic_seq;
  logic clock = 1'b0, reset_n = 1'b0, req = 1'b0, op = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0, wdata = '0;
  logic [7:0] rdata, core_din;
  logic busy, done, err, core_start, core_stop, core_rw, core_busy;
  logic [7:0] core_dout = 8'h55;
  int n_vec = 0, n_bad = 0;
  int cyc = 0, ndone = 0;
  logic both = 1'b0;
  logic [9:0] ev[$];
  int evc[$];
  logic [1:0] mode = 2'd0;
  logic [7:0] stick_din = 8'h00;
  logic [4:0] bcnt;
  logic stuck;

  iic_seq #(.TIMEOUT(64)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .op(op), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .core_start(core_start), .core_stop(core_stop), .core_rw(core_rw),
    .core_din(core_din), .core_dout(core_dout), .core_busy(core_busy)
  );

  always #5 clock = ~clock;

  // core model: busy 1 cycle after a strobe for 18 cycles; mode 1 never busy, mode 2 sticks on stick_din
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      bcnt  <= '0;
      stuck <= 1'b0;
    end else begin
      if (mode == 2'd0) stuck <= 1'b0;
      if ((core_start || core_stop) && mode != 2'd1) begin
        bcnt <= 5'd18;
        if (mode == 2'd2 && core_start && core_din == stick_din) stuck <= 1'b1;
      end else if (bcnt != 0) bcnt <= bcnt - 5'd1;
    end
  assign core_busy = bcnt != 0 || stuck;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (core_start) begin ev.push_back({1'b0, core_rw, core_din}); evc.push_back(cyc); end
    if (core_stop) begin ev.push_back(10'h200); evc.push_back(cyc); end
    if (core_start && core_stop) both = 1'b1;
    if (done) ndone++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic o, input logic [6:0] d, input logic [7:0] r, input logic [7:0] w);
    @(posedge clock); #1;
    req = 1'b1; op = o; dev_addr = d; reg_addr = r; wdata = w;
    @(posedge clock); #1;
    req = 1'b0;
    chk("accept_busy", {31'd0, busy}, 1);
    chk("first_start", {31'd0, core_start}, 1);
  endtask

  task automatic wait_done(output logic e);
    int k = 0;
    while (!done && k < 3000) begin @(posedge clock); #1; k++; end
    chk("done_seen", {31'd0, done}, 1);
    chk("busy_at_done", {31'd0, busy}, 1);
    e = err;
  endtask

  task automatic after_done();
    @(posedge clock); #1;
    chk("busy_after", {31'd0, busy}, 0);
    chk("done_pulse", {31'd0, done}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic e;
    int b, d0, k;
    #2;
    chk("rst_flags", {26'd0, busy, done, err, core_start, core_stop, core_rw}, 0);
    chk("rst_rdata", {24'd0, rdata}, 0);
    chk("rst_din", {24'd0, core_din}, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    b = ev.size(); d0 = ndone;
    send(1'b0, 7'h50, 8'h10, 8'hAA);
    wait_done(e);
    chk("wr_err", {31'd0, e}, 0);
    after_done();
    chk("wr_nev", ev.size() - b, 4);
    chk("wr_ev0", {22'd0, ev[b]}, 10'h0A0);
    chk("wr_ev1", {22'd0, ev[b+1]}, 10'h010);
    chk("wr_ev2", {22'd0, ev[b+2]}, 10'h0AA);
    chk("wr_ev3", {22'd0, ev[b+3]}, 10'h200);
    chk("wr_ndone", ndone - d0, 1);

    b = ev.size();
    send(1'b1, 7'h50, 8'h22, 8'h00);
    wait_done(e);
    chk("rd_err", {31'd0, e}, 0);
    chk("rd_rdata", {24'd0, rdata}, 8'h55);
    after_done();
    chk("rd_nev", ev.size() - b, 6);
    chk("rd_ev0", {22'd0, ev[b]}, 10'h0A0);
    chk("rd_ev1", {22'd0, ev[b+1]}, 10'h022);
    chk("rd_ev2", {22'd0, ev[b+2]}, 10'h200);
    chk("rd_ev3", {22'd0, ev[b+3]}, 10'h0A1);
    chk("rd_ev4_rw", {30'd0, ev[b+4][9:8]}, 2'b01);
    chk("rd_ev5", {22'd0, ev[b+5]}, 10'h200);

    b = ev.size(); d0 = ndone;
    send(1'b0, 7'h50, 8'h33, 8'h5C);
    repeat (4) @(posedge clock);
    #1 req = 1'b1; op = 1'b1; dev_addr = 7'h11; reg_addr = 8'h77;
    @(posedge clock); #1 req = 1'b0;
    wait_done(e);
    chk("rwb_err", {31'd0, e}, 0);
    chk("rwb_ev1", {22'd0, ev[b+1]}, 10'h033);
    chk("rwb_ev2", {22'd0, ev[b+2]}, 10'h05C);
    send(1'b0, 7'h12, 8'h34, 8'h56);
    wait_done(e);
    after_done();
    chk("rwb_b2b_ev", {22'd0, ev[b+4]}, 10'h024);
    repeat (60) @(posedge clock);
    #1 chk("rwb_ndone", ndone - d0, 2);
    chk("rwb_idle", {31'd0, busy}, 0);

    mode = 2'd1;
    b = ev.size();
    send(1'b1, 7'h50, 8'h22, 8'h00);
    wait_done(e);
    chk("sa_err", {31'd0, e}, 1);
    chk("sa_rdata", {24'd0, rdata}, 8'h55);
    after_done();
    chk("sa_nev", ev.size() - b, 2);
    chk("sa_ev1", {22'd0, ev[b+1]}, 10'h200);
    chk("sa_delay", evc[b+1] - evc[b], 64);
    mode = 2'd0;

    mode = 2'd2; stick_din = 8'h44;
    b = ev.size();
    send(1'b0, 7'h50, 8'h44, 8'h99);
    wait_done(e);
    chk("sm_err", {31'd0, e}, 1);
    after_done();
    chk("sm_nev", ev.size() - b, 3);
    chk("sm_ev2", {22'd0, ev[b+2]}, 10'h200);
    mode = 2'd0;
    k = 0;
    while (core_busy && k < 100) begin @(posedge clock); #1; k++; end
    b = ev.size();
    send(1'b0, 7'h50, 8'h45, 8'h66);
    wait_done(e);
    chk("sm_next_err", {31'd0, e}, 0);
    after_done();
    chk("sm_next_ev2", {22'd0, ev[b+2]}, 10'h066);

    b = ev.size();
    send(1'b1, 7'h50, 8'h22, 8'h00);
    k = 0;
    while (ev.size() - b < 4 && k < 500) begin @(posedge clock); #1; k++; end
    chk("rst_step3", {31'd0, ev.size() - b >= 4}, 1);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_flags", {26'd0, busy, done, err, core_start, core_stop, core_rw}, 0);
    chk("mid_rdata", {24'd0, rdata}, 0);
    chk("mid_din", {24'd0, core_din}, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    b = ev.size();
    send(1'b0, 7'h50, 8'h10, 8'hAA);
    wait_done(e);
    chk("post_rst_err", {31'd0, e}, 0);
    after_done();
    chk("post_rst_nev", ev.size() - b, 4);
    chk("post_rst_ev2", {22'd0, ev[b+2]}, 10'h0AA);

    chk("excl", {31'd0, both}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/iic_seq.md
# iic_seq

Register-transaction sequencer that sits between a host (CPU register bank or boot-time init ROM) and `iic_core`. It takes a single request (device address, register address, op, write data) and drives the core's `start`/`stop`/`rw`/`din` strobes byte by byte, tracking the core's `busy` handshake. It returns read data and a done/error status, and aborts with a STOP if the core stalls.

## Interface
- `TIMEOUT`, default 4096: cycles allowed per core handshake phase before abort; must be ≥ 2.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  request strobe; sampled only in IDLE.
- `op`  in  1  0 = register write, 1 = register read.
- `dev_addr`  in  7  I2C 7-bit device address.
- `reg_addr`  in  8  target register address.
- `wdata`  in  8  write data (ignored for reads).
- `rdata`  out  8  read data; updated only on a successful read.
- `busy`  out  1  high from the cycle after `req` acceptance to the `done` cycle inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 = timeout abort. Holds until the next acceptance.
- `core_start`  out  1  one-cycle byte strobe to `iic_core.start`.
- `core_stop`  out  1  one-cycle STOP strobe to `iic_core.stop`.
- `core_rw`  out  1  to `iic_core.rw`: 0 = transmit `din`, 1 = receive into `dout`.
- `core_din`  out  8  to `iic_core.din`.
- `core_dout`  in  8  from `iic_core.dout`.
- `core_busy`  in  1  from `iic_core.busy`.

## Operation
- **Reset:** all outputs 0; state IDLE; step 0; timeout counter 0.
- **Acceptance:** in IDLE with `req`=1, latch `op`, `dev_addr`, `reg_addr` and `wdata`, clear `err`, then go to ISSUE. A `req` seen outside IDLE is ignored, not queued.
- **Write steps:**
  - 0: start, din={dev,0}
  - 1: start, din=reg
  - 2: start, din=wdata
  - 3: stop
- **Read steps:**
  - 0: start, din={dev,0}
  - 1: start, din=reg
  - 2: stop
  - 3: start, din={dev,1}
  - 4: start, rw=1
  - 5: stop
- **States:**
  - IDLE.
  - ISSUE: pulse `core_start` or `core_stop` for the current step. Wait here while `core_busy`=1 from a previous operation, subject to the timeout.
  - WAIT_ACC: wait for `core_busy`=1.
  - WAIT_DONE: wait for `core_busy`=0.
  - ABORT.
  - DONE.
- **Transitions:**
  - ISSUE → WAIT_ACC after the strobe.
  - WAIT_ACC → WAIT_DONE on `core_busy`=1.
  - WAIT_DONE on `core_busy`=0: go to ISSUE of the next step, or DONE if this was the last step.
  - DONE → IDLE after one cycle.
- **Read capture:** on leaving WAIT_DONE of read step 4, `rdata` ← `core_dout`.
- **Strobe stability:** `core_din` and `core_rw` are set in ISSUE and held unchanged until WAIT_DONE exits. `core_rw`=0 at every step except read step 4.
- **Strobe exclusivity:** `core_start` and `core_stop` are never high in the same cycle.
- **Timeout counter:**
  - Clears on entry to ISSUE, WAIT_ACC and WAIT_DONE.
  - Increments every cycle in those states.
  - Reaching `TIMEOUT`-1 → ABORT.
- **ABORT:** pulse `core_stop` once (regardless of `core_busy`), then DONE with `err`=1. `rdata` is unchanged.
- **Reset mid-transaction:** immediate return to reset values. No STOP is issued; the core is reset by the same `reset_n`.

## Timing
- **First strobe:** `req` high in cycle N → `busy`=1 and the step-0 `core_start` pulse both in cycle N+1, provided `core_busy`=0.
- **Per-step cost:** 1 (ISSUE) + acceptance latency + core busy duration.
- **Done cycle:**
  - Last step's `core_busy` falls in cycle M → `done`=1, `busy`=1 in M+1.
  - `busy`=0 in M+2.
- **Back-to-back requests:** earliest next acceptance is in M+2 (IDLE).
- **Acceptance edge case:** if `core_busy` rises in the same cycle as the strobe, WAIT_ACC exits on the next cycle; no strobe is repeated.
- **Error flag:** `err` changes only at acceptance (cleared) and in ABORT (set).

## Test plan
Behavioural core model: busy rises 1 cycle after each strobe and stays high for 18 cycles; `TIMEOUT`=64.

- **Write:** dev=0x50, reg=0x10, wdata=0xAA → `core_din` sequence 0xA0, 0x10, 0xAA, then one `core_stop`; `done`=1, `err`=0; 3 `core_start` pulses.
- **Read:** dev=0x50, reg=0x22, model `dout`=0x55 → `core_din` sequence 0xA0, 0x22, stop, 0xA1, then a start with `core_rw`=1, then stop; `rdata`=0x55, `err`=0.
- **Request while busy:** second `req` 5 cycles after the first → ignored; exactly one `done`; afterwards a fresh `req` is accepted in the IDLE cycle following `done`.
- **Stall before acceptance:** model never asserts busy → after 63 cycles in WAIT_ACC, one `core_stop` pulse, `done`=1, `err`=1, `rdata` unchanged.
- **Stall mid-byte:** model busy stuck high after step 1 → abort, `err`=1. The next write completes with `err`=0.
- **Reset mid-read:** assert `reset_n`=0 during step 3 → all outputs 0 immediately, same cycle, asynchronous; after release a write completes normally.
